// File: rtl/notch_inverse_filter_if.sv
// Handshake bundle for the notch inverse filter: sample in, reconstructed sample out.
interface notch_inverse_filter_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic signed [WIDTH-1:0] y_in_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic signed [WIDTH-1:0] x_out_o;
  logic                    sat_o;

  modport master (
    output in_valid_i, y_in_i, out_ready_i,
    input  in_ready_o, out_valid_o, x_out_o, sat_o
  );
  modport slave (
    input  in_valid_i, y_in_i, out_ready_i,
    output in_ready_o, out_valid_o, x_out_o, sat_o
  );
endinterface

// File: rtl/notch_inverse_filter.sv
// Inverse of the DEM-DAC notch IIR: rebuilds x[n] from y[n] with one shared MAC
// stepped by a small FSM; the clamped output is fed back as history.
module notch_inverse_filter #(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 18,
  parameter int FRAC   = 15,
  parameter int ACC_W  = 48,
  parameter int B1     = -62325,
  parameter int B2     = 32768,
  parameter int A1     = -61702,
  parameter int A2     = 32116
) (
  input logic                  clk_i,
  input logic                  reset_i,
  input logic                  clear_i,
  notch_inverse_filter_if.slave bus
);
  localparam int PROD_W = WIDTH + COEF_W;
  localparam logic signed [COEF_W-1:0] C_A1  = COEF_W'(A1);
  localparam logic signed [COEF_W-1:0] C_A2  = COEF_W'(A2);
  localparam logic signed [COEF_W-1:0] C_NB1 = COEF_W'(-B1);
  localparam logic signed [COEF_W-1:0] C_NB2 = COEF_W'(-B2);
  localparam logic signed [ACC_W-1:0]  RND   = ACC_W'(1) << (FRAC-1);
  localparam logic signed [ACC_W-1:0]  X_MAX = ACC_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]  X_MIN = ~X_MAX;

  typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_t;
  state_t state, state_nx;

  logic [2:0]               term;
  logic signed [WIDTH-1:0]  y_cur, y_d1, y_d2, x_d1, x_d2;
  logic signed [ACC_W-1:0]  acc, rnd_sh;
  logic signed [COEF_W-1:0] coef;
  logic signed [WIDTH-1:0]  opnd;
  logic signed [PROD_W-1:0] prod;
  logic signed [WIDTH-1:0]  x_clamp, x_q;
  logic                     sat_hi, sat_lo, sat_q;
  // [0] pulses the cycle after SAT, [1] is the registered out_valid
  logic [1:0]               vld_pipe;
  logic                     accept, handshake;

  assign accept    = bus.in_valid_i && (state == IDLE);
  assign handshake = vld_pipe[1] && bus.out_ready_i;

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = vld_pipe[1];
  assign bus.x_out_o     = x_q;
  assign bus.sat_o       = sat_q;

  always_comb begin
    coef = '0;
    opnd = '0;
    case (term)
      3'd1: begin coef = C_A1;  opnd = y_d1; end
      3'd2: begin coef = C_A2;  opnd = y_d2; end
      3'd3: begin coef = C_NB1; opnd = x_d1; end
      3'd4: begin coef = C_NB2; opnd = x_d2; end
      default: ;
    endcase
    prod    = PROD_W'(coef) * PROD_W'(opnd);
    rnd_sh  = (acc + RND) >>> FRAC;
    sat_hi  = rnd_sh > X_MAX;
    sat_lo  = rnd_sh < X_MIN;
    x_clamp = sat_hi ? X_MAX[WIDTH-1:0] : sat_lo ? X_MIN[WIDTH-1:0] : rnd_sh[WIDTH-1:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = MAC;
      MAC:  if (term == 3'd4) state_nx = SAT;
      SAT:  state_nx = OUT;
      OUT:  if (handshake) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear_i) state_nx = IDLE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      term <= '0; y_cur <= '0; acc <= '0;
      y_d1 <= '0; y_d2 <= '0; x_d1 <= '0; x_d2 <= '0;
      x_q <= '0; sat_q <= 1'b0; vld_pipe <= '0;
    end else if (clear_i) begin
      term <= '0; y_cur <= '0; acc <= '0;
      y_d1 <= '0; y_d2 <= '0; x_d1 <= '0; x_d2 <= '0;
      x_q <= '0; sat_q <= 1'b0; vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= (state == SAT);
      vld_pipe[1] <= vld_pipe[0] || (vld_pipe[1] && !bus.out_ready_i);
      case (state)
        IDLE: if (accept) begin
          y_cur <= bus.y_in_i;
          acc   <= ACC_W'(bus.y_in_i) <<< FRAC;
          term  <= 3'd1;
        end
        MAC: begin
          acc  <= acc + ACC_W'(prod);
          term <= term + 3'd1;
        end
        SAT: begin
          x_q   <= x_clamp;
          sat_q <= sat_hi || sat_lo;
          y_d2  <= y_d1;
          y_d1  <= y_cur;
          x_d2  <= x_d1;
          x_d1  <= x_clamp;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_notch_inverse_filter.sv
// Random and directed bench for notch_inverse_filter against a plain-arithmetic difference-equation model.
module tb_notch_inverse_filter;
  localparam longint A1 = -61702, A2 = 32116, B1 = -62325, B2 = 32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  longint yh1, yh2, xh1, xh2;

  notch_inverse_filter_if #(.WIDTH(16)) bus ();

  notch_inverse_filter dut (
    .clk_i  (clk),
    .reset_i(rst_n),
    .clear_i(clear),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  task automatic model_clear();
    yh1 = 0; yh2 = 0; xh1 = 0; xh2 = 0;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
  endtask

  // x[n] = y + a1*y1 + a2*y2 - b1*x1 - b2*x2, rounded half-up and clamped to Q1.15
  task automatic ref_x(input longint y, output longint ex, output longint es);
    longint acc, r;
    acc = y * 32768 + A1 * yh1 + A2 * yh2 - B1 * xh1 - B2 * xh2;
    r   = (acc + 16384) >>> 15;
    es  = 0;
    ex  = r;
    if (r > 32767)  begin ex = 32767;  es = 1; end
    if (r < -32768) begin ex = -32768; es = 1; end
  endtask

  task automatic xfer(input longint y, input int hold, input bit pulse,
                      output longint xo, output longint so);
    int lat;
    longint ex, es;
    bit extra;
    ref_x(y, ex, es);
    @(negedge clk);
    chk("rdy_pre", bus.in_ready_o, 1);
    bus.in_valid_i = 1'b1;
    bus.y_in_i = 16'(y);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 0;
    while (!bus.out_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (pulse && lat == 2) begin bus.in_valid_i = 1'b1; bus.y_in_i = 16'sd12345; end
      if (pulse && lat == 3) bus.in_valid_i = 1'b0;
    end
    chk("latency", lat, 6);
    xo = bus.x_out_o;
    so = bus.sat_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == hold - 1 || i == 0) begin
        chk("bp_x", bus.x_out_o, xo);
        chk("bp_sat", bus.sat_o, so);
        chk("bp_vld", bus.out_valid_o, 1);
        chk("bp_rdy", bus.in_ready_o, 0);
      end
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk("vld_drop", bus.out_valid_o, 0);
    chk("rdy_back", bus.in_ready_o, 1);
    chk("x", xo, ex);
    chk("sat", so, es);
    yh2 = yh1; yh1 = y; xh2 = xh1; xh1 = ex;
    if (pulse) begin
      extra = 1'b0;
      repeat (10) begin @(posedge clk); #1; extra |= bus.out_valid_o; end
      chk("no_extra_out", extra, 0);
    end
  endtask

  initial begin
    longint xo, so, y;
    bit seen;
    bus.in_valid_i = 1'b0;
    bus.y_in_i = '0;
    bus.out_ready_i = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", bus.in_ready_o, 1);
    chk("rst_vld", bus.out_valid_o, 0);
    chk("rst_x", bus.x_out_o, 0);
    chk("rst_sat", bus.sat_o, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      xfer(0, 0, 0, xo, so);
      chk("zero_x", xo, 0);
    end

    do_clear();
    xfer(16384, 0, 0, xo, so); chk("imp0", xo, 16384); chk("imp0_sat", so, 0);
    xfer(0, 0, 0, xo, so);     chk("imp1", xo, 312);   chk("imp1_sat", so, 0);
    xfer(0, 0, 0, xo, so);     chk("imp2", xo, 267);   chk("imp2_sat", so, 0);

    do_clear();
    xfer(32767, 0, 0, xo, so); chk("satA", xo, 32767); chk("satA_flag", so, 0);
    xfer(32767, 0, 0, xo, so); chk("satB", xo, 32767); chk("satB_flag", so, 1);

    xfer(-1200, 10, 0, xo, so);

    // async reset while the MAC is running
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.y_in_i = 16'sd9000;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("abort_rdy", bus.in_ready_o, 1);
    chk("abort_vld", bus.out_valid_o, 0);
    @(negedge clk); rst_n = 1'b1;
    model_clear();
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= bus.out_valid_o; end
    chk("abort_noout", seen, 0);
    xfer(16384, 0, 0, xo, so); chk("post_rst0", xo, 16384);
    xfer(0, 0, 0, xo, so);     chk("post_rst1", xo, 312);

    // clear while a result is waiting in OUT
    @(negedge clk);
    bus.in_valid_i = 1'b1; bus.y_in_i = 16'sd5000;
    @(posedge clk); #1; bus.in_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(posedge clk); #1; seen = bus.out_valid_o; end
    chk("clr_pending", seen, 1);
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    chk("clr_vld", bus.out_valid_o, 0);
    chk("clr_rdy", bus.in_ready_o, 1);
    model_clear();
    xfer(16384, 0, 0, xo, so); chk("post_clr0", xo, 16384);
    xfer(0, 0, 0, xo, so);     chk("post_clr1", xo, 312);

    xfer(700, 0, 1, xo, so);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      if ($urandom_range(0, 3) == 0) y = longint'($urandom_range(0, 65535)) - 32768;
      else                           y = longint'($urandom_range(0, 4000)) - 2000;
      xfer(y, int'($urandom_range(0, 3)), 0, xo, so);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got %0d of %0d checks", n_pass, n_chk);
    $fatal(1);
  end
endmodule
